// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, bubble, flush, debug drain/halt and performance counters for the in-order pipeline
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_resp,
  input  logic                  dcache_resp,
  input  logic                  mem_req,
  input  logic                  redirect,
  input  logic                  ex_is_load,
  input  logic [4:0]            ex_rd,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  halt_req,
  input  logic                  resume,
  input  logic                  clr_cnt,
  output logic                  icache_read,
  output logic [NUM_STAGES-1:0] stage_ld,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      retire_cnt
);
  localparam int M = NUM_STAGES - 2;
  localparam int W = NUM_STAGES - 1;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state;
  logic [W:1] valid, valid_nxt;
  logic run, istall, dstall, adv, redir, src_hit, hazard;
  assign run = state == RUN;
  assign icache_read = rst & run;
  assign istall = icache_read & !icache_resp;
  assign dstall = valid[M] & mem_req & !dcache_resp;
  assign adv = rst & !(istall | dstall);
  assign redir = adv & valid[M] & redirect;
  assign src_hit = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
  assign hazard = adv & !redir & valid[2] & valid[1] & ex_is_load & (ex_rd != 5'd0) & src_hit;
  // Outside RUN the PC only moves to take a redirect target; fetch stays idle.
  assign stage_ld = adv ? {{(NUM_STAGES-2){1'b1}}, !hazard, !hazard & (run | redir)} : '0;
  assign stage_valid = {valid, icache_read};
  assign halted = state == HALTED;
  always_comb begin
    valid_nxt = {valid[W-1:1], run};
    if (hazard) valid_nxt[2:1] = {1'b0, valid[1]};
    if (redir) valid_nxt[FLUSH_DEPTH:1] = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      state <= RUN;
      stall_cnt <= '0;
      bubble_cnt <= '0;
      flush_cnt <= '0;
      retire_cnt <= '0;
    end else begin
      if (adv) valid <= valid_nxt;
      state <= (run && halt_req && adv) ? DRAIN :
               (state == DRAIN && valid == '0) ? HALTED :
               (state == HALTED && resume) ? RUN : state;
      stall_cnt <= clr_cnt ? '0 : stall_cnt + CNT_W'(!adv);
      bubble_cnt <= clr_cnt ? '0 : bubble_cnt + CNT_W'(hazard);
      flush_cnt <= clr_cnt ? '0 : flush_cnt + CNT_W'(redir);
      retire_cnt <= clr_cnt ? '0 : retire_cnt + CNT_W'(adv & valid[W]);
    end
  end
endmodule
